// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, BCD digit limits
// and the system clock frequency used by the timer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX     = 4'd9;

    localparam int FREQUENCY = 10_000_000;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with synchronous clear and a combinational
// carry that fires on the increment which wraps the digit back to 0.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = ONES_MAX
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc && (q == MAX);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch control FSM and MM:SS BCD count. Consumes one-cycle second_tick
// pulses from the timer and gates the timer through enable.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       second_tick,
    output logic       enable,
    output logic       running,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       rollover,
    output state_t     state_dbg
);

    // All control inputs are single-cycle pulses with no backpressure: a pulse
    // is consumed on the edge that samples it and is never held or retried.

    state_t state, state_next;

    logic tick_en;
    logic at_max;
    logic terminal;
    logic inc_so;
    logic c_so, c_st, c_mo, c_mt;

    assign tick_en = (state == RUN) && second_tick;
    assign at_max  = (sec_ones == ONES_MAX) && (sec_tens == SEC_TENS_MAX) &&
                     (min_ones == ONES_MAX) && (min_tens == MIN_TENS_MAX);

    // In saturating mode the chain is not advanced at 59:59, so the count holds.
    assign inc_so   = tick_en && (WRAP || !at_max);
    assign terminal = WRAP ? c_mt : (tick_en && at_max);

    bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
        .clk(clk), .nrst(nrst), .clr(clear), .inc(inc_so), .q(sec_ones), .carry(c_so)
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .nrst(nrst), .clr(clear), .inc(c_so), .q(sec_tens), .carry(c_st)
    );
    bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
        .clk(clk), .nrst(nrst), .clr(clear), .inc(c_st), .q(min_ones), .carry(c_mo)
    );
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .nrst(nrst), .clr(clear), .inc(c_mo), .q(min_tens), .carry(c_mt)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            rollover <= 1'b0;
        end else begin
            state    <= state_next;
            rollover <= terminal && !clear;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            if (start_stop) begin
                case (state)
                    IDLE:    state_next = RUN;
                    RUN:     state_next = PAUSE;
                    PAUSE:   state_next = RUN;
                    default: state_next = IDLE;
                endcase
            end
            if (terminal && !WRAP) begin
                state_next = PAUSE;
            end
        end
    end

    assign enable    = (state == RUN);
    assign running   = enable;
    assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a wrapping and a saturating instance share the
// same stimulus and are compared against a seconds-based reference model.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic second_tick = 1'b0;

    logic       w_enable, w_running, w_rollover;
    logic [3:0] w_so, w_st, w_mo, w_mt;
    state_t     w_state;
    logic       s_enable, s_running, s_rollover;
    logic [3:0] s_so, s_st, s_mo, s_mt;
    state_t     s_state;

    wire [15:0] w_digits = {w_mt, w_mo, w_st, w_so};
    wire [15:0] s_digits = {s_mt, s_mo, s_st, s_so};

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 = wrapping, 1 = saturating.
    // mode 0 = idle, 1 = run, 2 = pause; cnt is elapsed seconds 0..3599.
    int m_cnt [2];
    int m_mode[2];
    bit m_roll[2];

    always #50 clk = ~clk;

    stopwatch_counter #(.WRAP(1'b1)) dut_wrap (
        .clk(clk), .nrst(nrst), .start_stop(start_stop), .clear(clear),
        .second_tick(second_tick), .enable(w_enable), .running(w_running),
        .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
        .rollover(w_rollover), .state_dbg(w_state)
    );

    stopwatch_counter #(.WRAP(1'b0)) dut_sat (
        .clk(clk), .nrst(nrst), .start_stop(start_stop), .clear(clear),
        .second_tick(second_tick), .enable(s_enable), .running(s_running),
        .sec_ones(s_so), .sec_tens(s_st), .min_ones(s_mo), .min_tens(s_mt),
        .rollover(s_rollover), .state_dbg(s_state)
    );

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic exp_en(input int idx);
        return m_mode[idx] == 1;
    endfunction

    task automatic model_step(input logic ss, input logic clr, input logic tk, input logic rst_n);
        for (int i = 0; i < 2; i++) begin
            int old_mode;
            old_mode = m_mode[i];
            m_roll[i] = 1'b0;
            if (!rst_n || clr) begin
                m_cnt[i]  = 0;
                m_mode[i] = 0;
            end else begin
                if (ss) m_mode[i] = (old_mode == 1) ? 2 : 1;
                if (tk && old_mode == 1) begin
                    if (m_cnt[i] == 3599) begin
                        m_roll[i] = 1'b1;
                        if (i == 0) m_cnt[i] = 0;
                        else        m_mode[i] = 2;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic ss, input logic clr, input logic tk, input logic rst_n);
        start_stop  = ss;
        clear       = clr;
        second_tick = tk;
        nrst        = rst_n;
        @(posedge clk);
        model_step(ss, clr, tk, rst_n);
        @(negedge clk);
        start_stop  = 1'b0;
        clear       = 1'b0;
        second_tick = 1'b0;
        nrst        = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (w_digits !== 16'h0000 || s_digits !== 16'h0000) begin
            errors++; $display("FAIL reset_digits actual=%h/%h expected=0000", w_digits, s_digits);
        end
        checks++; if (w_enable !== 1'b0 || s_enable !== 1'b0 || w_running !== 1'b0) begin
            errors++; $display("FAIL reset_enable actual=%b/%b expected=0", w_enable, s_enable);
        end
        checks++; if (w_rollover !== 1'b0 || s_rollover !== 1'b0) begin
            errors++; $display("FAIL reset_rollover actual=%b/%b expected=0", w_rollover, s_rollover);
        end
    endtask

    task automatic test_start_61;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (w_enable !== 1'b1 || w_running !== 1'b1) begin
            errors++; $display("FAIL start_enable actual=%b expected=1", w_enable);
        end
        ticks(61);
        checks++; if (w_digits !== to_bcd(m_cnt[0]) || s_digits !== to_bcd(m_cnt[1])) begin
            errors++; $display("FAIL start61_model actual=%h expected=%h", w_digits, to_bcd(m_cnt[0]));
        end
        checks++; if (w_mo !== 4'd1 || w_st !== 4'd0 || w_so !== 4'd1 || w_mt !== 4'd0) begin
            errors++; $display("FAIL start61_digits actual=%h expected=0101", w_digits);
        end
    endtask

    task automatic test_pause_drops;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(5);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(3);
        checks++; if (w_digits !== 16'h0005 || w_enable !== 1'b0) begin
            errors++; $display("FAIL pause_hold actual=%h en=%b expected=0005 en=0", w_digits, w_enable);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(1);
        checks++; if (w_digits !== 16'h0006 || w_enable !== 1'b1) begin
            errors++; $display("FAIL pause_resume actual=%h en=%b expected=0006 en=1", w_digits, w_enable);
        end
    endtask

    task automatic test_simultaneous;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(9);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (w_digits !== 16'h0010 || w_enable !== 1'b0) begin
            errors++; $display("FAIL tick_with_stop actual=%h en=%b expected=0010 en=0", w_digits, w_enable);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (w_digits !== 16'h0000 || w_enable !== 1'b0 || w_rollover !== 1'b0) begin
            errors++; $display("FAIL clear_priority actual=%h en=%b expected=0000 en=0", w_digits, w_enable);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (w_digits !== 16'h0000) begin
            errors++; $display("FAIL idle_drops_tick actual=%h expected=0000", w_digits);
        end
    endtask

    task automatic test_reset_mid_count;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(754);
        checks++; if (w_digits !== 16'h1234 || s_digits !== 16'h1234) begin
            errors++; $display("FAIL reach_1234 actual=%h/%h expected=1234", w_digits, s_digits);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (w_digits !== 16'h0000 || w_enable !== 1'b0 || w_rollover !== 1'b0) begin
            errors++; $display("FAIL reset_mid actual=%h en=%b expected=0000 en=0", w_digits, w_enable);
        end
    endtask

    task automatic test_terminal;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(3599);
        checks++; if (w_digits !== 16'h5959 || s_digits !== 16'h5959) begin
            errors++; $display("FAIL reach_5959 actual=%h/%h expected=5959", w_digits, s_digits);
        end
        ticks(1);
        checks++; if (w_digits !== 16'h0000 || w_rollover !== 1'b1 || w_enable !== 1'b1) begin
            errors++; $display("FAIL wrap actual=%h roll=%b en=%b expected=0000 roll=1 en=1",
                               w_digits, w_rollover, w_enable);
        end
        checks++; if (s_digits !== 16'h5959 || s_rollover !== 1'b1 || s_enable !== 1'b0) begin
            errors++; $display("FAIL saturate actual=%h roll=%b en=%b expected=5959 roll=1 en=0",
                               s_digits, s_rollover, s_enable);
        end
        ticks(1);
        checks++; if (w_rollover !== 1'b0 || s_rollover !== 1'b0 || w_digits !== 16'h0001) begin
            errors++; $display("FAIL roll_one_cycle actual=%b/%b digits=%h expected=0/0 0001",
                               w_rollover, s_rollover, w_digits);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (s_enable !== 1'b1) begin
            errors++; $display("FAIL sat_restart actual=%b expected=1", s_enable);
        end
        ticks(1);
        checks++; if (s_digits !== 16'h5959 || s_rollover !== 1'b1 || s_enable !== 1'b0) begin
            errors++; $display("FAIL sat_again actual=%h roll=%b en=%b expected=5959 roll=1 en=0",
                               s_digits, s_rollover, s_enable);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            logic ss, clr, tk, rst_n;
            tk    = ($urandom_range(0, 3) != 0);
            ss    = ($urandom_range(0, 40) == 0);
            clr   = ($urandom_range(0, 400) == 0);
            rst_n = ($urandom_range(0, 1500) != 0);
            drive(ss, clr, tk, rst_n);
            checks++;
            if (w_digits !== to_bcd(m_cnt[0]) || w_enable !== exp_en(0) ||
                w_running !== exp_en(0) || w_rollover !== m_roll[0]) begin
                errors++;
                $display("FAIL random_wrap cyc=%0d actual=%h en=%b roll=%b expected=%h en=%b roll=%b",
                         c, w_digits, w_enable, w_rollover, to_bcd(m_cnt[0]), exp_en(0), m_roll[0]);
            end
            checks++;
            if (s_digits !== to_bcd(m_cnt[1]) || s_enable !== exp_en(1) ||
                s_running !== exp_en(1) || s_rollover !== m_roll[1]) begin
                errors++;
                $display("FAIL random_sat cyc=%0d actual=%h en=%b roll=%b expected=%h en=%b roll=%b",
                         c, s_digits, s_enable, s_rollover, to_bcd(m_cnt[1]), exp_en(1), m_roll[1]);
            end
        end
    endtask

    task automatic test_random_near_terminal;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(3590);
        test_random;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_mode[i] = 0; m_roll[i] = 1'b0;
        end
        @(negedge clk);
        test_reset;
        test_start_61;
        test_pause_drops;
        test_simultaneous;
        test_reset_mid_count;
        test_terminal;
        test_random;
        test_random_near_terminal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
